// File: rtl/sap_controller_sequencer_if.sv
// SAP-1 controller-sequencer bus: IR opcode in; T-state ring, 12-bit control word and halt out.
interface sap_controller_sequencer_if;
    localparam int unsigned OP_W = 4;
    localparam int unsigned T_W  = 6;

    logic [OP_W-1:0] opcode;
    logic [T_W-1:0]  t_state;
    logic            cp;
    logic            ep;
    logic            lm_bar;
    logic            ce_bar;
    logic            li_bar;
    logic            ei_bar;
    logic            la_bar;
    logic            ea;
    logic            su;
    logic            eu;
    logic            lb_bar;
    logic            lo_bar;
    logic            hlt;

    // Sequencer side
    modport master (
        input  opcode,
        output t_state, cp, ep, lm_bar, ce_bar, li_bar, ei_bar,
               la_bar, ea, su, eu, lb_bar, lo_bar, hlt
    );

    // Datapath side
    modport slave (
        output opcode,
        input  t_state, cp, ep, lm_bar, ce_bar, li_bar, ei_bar,
               la_bar, ea, su, eu, lb_bar, lo_bar, hlt
    );
endinterface

// File: rtl/sap_controller_sequencer.sv
// SAP-1 controller-sequencer: one-hot T1..T6 ring decoded with the IR opcode into the control word.
// Define SAP_SEQ_SKIP_NOP_EN to end each instruction right after its last non-empty T-state.
module sap_controller_sequencer (
    input  logic                        clk,
    input  logic                        clr,
    sap_controller_sequencer_if.master  bus
);
    localparam int unsigned OP_W = 4;
    localparam int unsigned T_W  = 6;

    localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
    localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

    localparam logic [T_W-1:0] T1 = 6'b000001;
    localparam logic [T_W-1:0] T2 = 6'b000010;
    localparam logic [T_W-1:0] T3 = 6'b000100;
    localparam logic [T_W-1:0] T4 = 6'b001000;
    localparam logic [T_W-1:0] T5 = 6'b010000;
    localparam logic [T_W-1:0] T6 = 6'b100000;

    logic [T_W-1:0] t_state_q;
    logic [T_W-1:0] t_state_d;
    logic           halted_q;
    logic           halted_d;

    logic op_lda;
    logic op_add;
    logic op_sub;
    logic op_out;
    logic op_hlt;
`ifdef SAP_SEQ_SKIP_NOP_EN
    logic op_nop;
`endif

    logic cp_c;
    logic ep_c;
    logic lm_bar_c;
    logic ce_bar_c;
    logic li_bar_c;
    logic ei_bar_c;
    logic la_bar_c;
    logic ea_c;
    logic su_c;
    logic eu_c;
    logic lb_bar_c;
    logic lo_bar_c;
    logic hlt_c;

    // Opcode decode
    always_comb begin
        op_lda = (bus.opcode == OP_LDA);
        op_add = (bus.opcode == OP_ADD);
        op_sub = (bus.opcode == OP_SUB);
        op_out = (bus.opcode == OP_OUT);
        op_hlt = (bus.opcode == OP_HLT);
`ifdef SAP_SEQ_SKIP_NOP_EN
        op_nop = !(op_lda || op_add || op_sub || op_out || op_hlt);
`endif
    end

    // State register: ring position and halt latch
    always_ff @(posedge clk) begin
        if (!clr) begin
            t_state_q <= T1;
            halted_q  <= 1'b0;
        end else begin
            t_state_q <= t_state_d;
            halted_q  <= halted_d;
        end
    end

    // Next state: ring advance; HLT parks the ring on T5 until clr
    always_comb begin
        t_state_d = t_state_q;
        halted_d  = halted_q;
        if (!halted_q) begin
            case (t_state_q)
                T1: t_state_d = T2;
                T2: t_state_d = T3;
                T3: t_state_d = T4;
                T4: begin
                    if (op_hlt) begin
                        t_state_d = T5;
                        halted_d  = 1'b1;
                    end
`ifdef SAP_SEQ_SKIP_NOP_EN
                    else if (op_out || op_nop) begin
                        t_state_d = T1;
                    end
`endif
                    else begin
                        t_state_d = T5;
                    end
                end
                T5: begin
`ifdef SAP_SEQ_SKIP_NOP_EN
                    if (op_lda) begin
                        t_state_d = T1;
                    end else begin
                        t_state_d = T6;
                    end
`else
                    t_state_d = T6;
`endif
                end
                T6:      t_state_d = T1;
                default: t_state_d = T1;
            endcase
        end
    end

    // Control word decode; everything inactive while clr is low
    always_comb begin
        cp_c     = 1'b0;
        ep_c     = 1'b0;
        lm_bar_c = 1'b1;
        ce_bar_c = 1'b1;
        li_bar_c = 1'b1;
        ei_bar_c = 1'b1;
        la_bar_c = 1'b1;
        ea_c     = 1'b0;
        su_c     = 1'b0;
        eu_c     = 1'b0;
        lb_bar_c = 1'b1;
        lo_bar_c = 1'b1;
        hlt_c    = 1'b0;
        if (clr) begin
            if (halted_q) begin
                hlt_c = 1'b1;
            end else begin
                case (t_state_q)
                    T1: begin
                        ep_c     = 1'b1;
                        lm_bar_c = 1'b0;
                    end
                    T2: cp_c = 1'b1;
                    T3: begin
                        ce_bar_c = 1'b0;
                        li_bar_c = 1'b0;
                    end
                    T4: begin
                        if (op_lda || op_add || op_sub) begin
                            ei_bar_c = 1'b0;
                            lm_bar_c = 1'b0;
                        end else if (op_out) begin
                            ea_c     = 1'b1;
                            lo_bar_c = 1'b0;
                        end else if (op_hlt) begin
                            hlt_c = 1'b1;
                        end
                    end
                    T5: begin
                        if (op_lda) begin
                            ce_bar_c = 1'b0;
                            la_bar_c = 1'b0;
                        end else if (op_add || op_sub) begin
                            ce_bar_c = 1'b0;
                            lb_bar_c = 1'b0;
                        end
                    end
                    T6: begin
                        if (op_add || op_sub) begin
                            eu_c     = 1'b1;
                            la_bar_c = 1'b0;
                            su_c     = op_sub;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.t_state = t_state_q;
    assign bus.cp      = cp_c;
    assign bus.ep      = ep_c;
    assign bus.lm_bar  = lm_bar_c;
    assign bus.ce_bar  = ce_bar_c;
    assign bus.li_bar  = li_bar_c;
    assign bus.ei_bar  = ei_bar_c;
    assign bus.la_bar  = la_bar_c;
    assign bus.ea      = ea_c;
    assign bus.su      = su_c;
    assign bus.eu      = eu_c;
    assign bus.lb_bar  = lb_bar_c;
    assign bus.lo_bar  = lo_bar_c;
    assign bus.hlt     = hlt_c;

    // At most one bus driver per state
    logic [4:0] bus_drv;
    assign bus_drv = {ep_c, ~ce_bar_c, ~ei_bar_c, ea_c, eu_c};

    a_bus_excl: assert property (@(posedge clk) $onehot0(bus_drv));
    a_halt_park: assert property (@(posedge clk) disable iff (!clr) halted_q |-> (t_state_q == T5));

endmodule
